ps2_key_registers: RTL and testbench

//  Keyboard end of the memory-mapped key interface. Receives PS/2 set-2 scancodes and decodes them.

---
 rtl/ps2_key_registers_pkg.sv | 27 ++
 rtl/ps2_key_registers_rx.sv | 93 +++++++++
 rtl/ps2_key_registers.sv | 63 ++++++
 tb/tb_ps2_key_registers.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_registers_pkg.sv
// ps2_key_registers_pkg: scancodes, key addresses and receiver types shared by the key interface
package ps2_key_registers_pkg;
    localparam int NUM_KEYS = 6;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [13:0] ADDR_FORWARD   = 14'h3FFE;
    localparam logic [13:0] ADDR_BACKWARD  = 14'h3FFD;
    localparam logic [13:0] ADDR_TURNRIGHT = 14'h3FFC;
    localparam logic [13:0] ADDR_TURNLEFT  = 14'h3FFB;
    localparam logic [13:0] ADDR_SHOOT     = 14'h3FFA;
    localparam logic [13:0] ADDR_RESET     = 14'h3FF9;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    // Bit order matches the status registers: W, S, D, A, Space, Esc.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
        return {code == KEY_ESC, code == KEY_SPACE, code == KEY_A,
                code == KEY_D, code == KEY_S, code == KEY_W};
    endfunction
    function automatic logic [15:0] key_word(input logic held, input logic sticky);
        return {14'b0, sticky, held};
    endfunction
endpackage

// File: rtl/ps2_key_registers_rx.sv
// ps2_key_registers_rx: PS/2 synchronizer, clock filter and frame receiver with idle timeout
module ps2_key_registers_rx
    import ps2_key_registers_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [1:0] clk_sync, data_sync;
    logic filt_clk, filt_prev, strobe, bit_in, parity;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] idle_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    rx_state_t state;
    assign strobe = filt_prev & ~filt_clk;
    assign bit_in = data_sync[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_prev <= filt_clk;
            if (clk_sync[1] == filt_clk)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + FW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            idle_cnt   <= '0;
            scan_valid <= 1'b0;
            scan_code  <= '0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            idle_cnt   <= (state == RX_IDLE || strobe) ? '0 : idle_cnt + TW'(1);
            // A stalled frame is abandoned; its partial bits are simply left behind.
            if (state != RX_IDLE && !strobe && idle_cnt == TW'(TIMEOUT - 1)) begin
                state     <= RX_IDLE;
                frame_err <= 1'b1;
            end else if (strobe) begin
                case (state)
                    RX_IDLE: begin
                        state     <= bit_in ? RX_IDLE : RX_DATA;
                        frame_err <= bit_in;
                        bit_cnt   <= '0;
                    end
                    RX_DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= (bit_cnt == 3'd7) ? RX_PARITY : RX_DATA;
                    end
                    RX_PARITY: begin
                        parity <= bit_in;
                        state  <= RX_STOP;
                    end
                    default: begin
                        if (bit_in && ^{shift, parity}) begin
                            scan_valid <= 1'b1;
                            scan_code  <= shift;
                        end else
                            frame_err <= 1'b1;
                        state <= RX_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_key_registers.sv
// ps2_key_registers: decodes PS/2 set-2 scancodes into held/sticky status words for six game keys
module ps2_key_registers
    import ps2_key_registers_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        Keyboard_reset,
    output logic [15:0] FORWARD_Out,
    output logic [15:0] BACKWARD_Out,
    output logic [15:0] TURNRIGHT_Out,
    output logic [15:0] TURNLEFT_Out,
    output logic [15:0] SHOOT_Out,
    output logic [15:0] RESET_Out,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);
    logic [NUM_KEYS-1:0] held, sticky, hit, make_keys, break_keys;
    logic brk, ext, key_byte;
    ps2_key_registers_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );
    assign hit        = key_onehot(scan_code);
    assign key_byte   = scan_valid && !ext && scan_code != SC_BREAK && scan_code != SC_EXT;
    assign make_keys  = (key_byte && !brk) ? hit : '0;
    assign break_keys = (key_byte && brk) ? hit : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held   <= '0;
            sticky <= '0;
            brk    <= 1'b0;
            ext    <= 1'b0;
        end else begin
            held <= (held & ~break_keys) | make_keys;
            // A make in the same cycle as a clear request still leaves its sticky bit set.
            sticky <= (Keyboard_reset ? '0 : sticky) | make_keys;
            if (frame_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (scan_valid) begin
                brk <= scan_code == SC_BREAK || (brk && scan_code == SC_EXT);
                ext <= scan_code == SC_EXT || (ext && scan_code == SC_BREAK);
            end
        end
    end
    assign FORWARD_Out   = key_word(held[0], sticky[0]);
    assign BACKWARD_Out  = key_word(held[1], sticky[1]);
    assign TURNRIGHT_Out = key_word(held[2], sticky[2]);
    assign TURNLEFT_Out  = key_word(held[3], sticky[3]);
    assign SHOOT_Out     = key_word(held[4], sticky[4]);
    assign RESET_Out     = key_word(held[5], sticky[5]);
endmodule

// File: tb/tb_ps2_key_registers.sv
// tb_ps2_key_registers: directed PS/2 frames checked against a key-state model of the decoder
module tb_ps2_key_registers;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;
    logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, Keyboard_reset = 1'b0;
    logic [15:0] FORWARD_Out, BACKWARD_Out, TURNRIGHT_Out, TURNLEFT_Out, SHOOT_Out, RESET_Out;
    logic scan_valid, frame_err;
    logic [7:0] scan_code;
    logic [15:0] dut_w [6];
    int n_checks = 0, n_fail = 0, n_valid = 0, n_err = 0, exp_valid = 0, exp_err = 0;
    logic chk_en = 1'b0;
    logic [7:0] key_codes [6] = '{8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h29, 8'h76};
    logic m_held [6] = '{default: 1'b0};
    logic m_sticky [6] = '{default: 1'b0};
    logic m_brk = 1'b0, m_ext = 1'b0;
    logic [7:0] m_code = 8'h00;
    ps2_key_registers #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .Keyboard_reset (Keyboard_reset),
        .FORWARD_Out    (FORWARD_Out),
        .BACKWARD_Out   (BACKWARD_Out),
        .TURNRIGHT_Out  (TURNRIGHT_Out),
        .TURNLEFT_Out   (TURNLEFT_Out),
        .SHOOT_Out      (SHOOT_Out),
        .RESET_Out      (RESET_Out),
        .scan_valid     (scan_valid),
        .scan_code      (scan_code),
        .frame_err      (frame_err)
    );
    assign dut_w[0] = FORWARD_Out;
    assign dut_w[1] = BACKWARD_Out;
    assign dut_w[2] = TURNRIGHT_Out;
    assign dut_w[3] = TURNLEFT_Out;
    assign dut_w[4] = SHOOT_Out;
    assign dut_w[5] = RESET_Out;
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            for (int i = 0; i < 6; i++)
                if (!m_ext && key_codes[i] == b) begin
                    m_held[i] = !m_brk;
                    if (!m_brk) m_sticky[i] = 1'b1;
                end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        m_code = b;
        exp_valid++;
    endtask
    task automatic model_err();
        m_brk = 1'b0;
        m_ext = 1'b0;
        exp_err++;
    endtask
    function automatic logic [15:0] exp_word(input int i);
        return {14'b0, m_sticky[i], m_held[i]};
    endfunction
    always @(negedge clk) begin
        if (scan_valid) n_valid++;
        if (frame_err) n_err++;
    end
    always @(negedge clk)
        if (chk_en) begin
            for (int i = 0; i < 6; i++) check($sformatf("key_word[%0d]", i), dut_w[i], exp_word(i));
            check("scan_code", {8'h00, scan_code}, {8'h00, m_code});
            check("idle_pulses", {14'b0, scan_valid, frame_err}, 16'h0000);
        end
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask
    task automatic check_counts();
        check("valid_count", 16'(n_valid), 16'(exp_valid));
        check("err_count", 16'(n_err), 16'(exp_err));
    endtask
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        chk_en = 1'b0;
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        if (bad_par || bad_stop) model_err(); else model_byte(b);
        check_counts();
        chk_en = 1'b1;
    endtask
    task automatic kb_pulse();
        chk_en = 1'b0;
        Keyboard_reset = 1'b1;
        @(negedge clk);
        Keyboard_reset = 1'b0;
        for (int i = 0; i < 6; i++) m_sticky[i] = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
    endtask
    initial begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) check("reset_word", dut_w[i], 16'h0000);
        check("reset_pulses", {6'b0, scan_valid, frame_err, scan_code}, 16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        // Make W: held and sticky both set.
        send_frame(8'h1D, 1'b0, 1'b0);
        check("w_make", FORWARD_Out, 16'h0003);
        // Break W keeps only the sticky bit, clear request drops it.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check("w_break", FORWARD_Out, 16'h0002);
        kb_pulse();
        check("w_cleared", FORWARD_Out, 16'h0000);
        // Space make lands in the same cycle as a clear request.
        fork
            send_frame(8'h29, 1'b0, 1'b0);
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!scan_valid && t < 1000);
                if (!scan_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL space_valid_wait: got timeout expected scan_valid");
                end
                Keyboard_reset = 1'b1;
                for (int i = 0; i < 6; i++) m_sticky[i] = 1'b0;
                @(negedge clk);
                Keyboard_reset = 1'b0;
            end
        join
        check("space_make_wins", SHOOT_Out, 16'h0003);
        // Bad parity on A: error pulse only.
        send_frame(8'h1C, 1'b1, 1'b0);
        check("a_bad_parity", TURNLEFT_Out, 16'h0000);
        // Break prefix is dropped by a corrupted frame, so D is a make.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b1);
        send_frame(8'h23, 1'b0, 1'b0);
        check("d_prefix_dropped", TURNRIGHT_Out, 16'h0003);
        // Extended W is ignored.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check("ext_w_ignored", FORWARD_Out, 16'h0000);
        // Break prefix, then a stalled frame; the timeout must drop the prefix too.
        send_frame(8'hF0, 1'b0, 1'b0);
        chk_en = 1'b0;
        send_bits({2'b11, 8'h55, 1'b0}, 5);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(negedge clk);
        model_err();
        check_counts();
        chk_en = 1'b1;
        send_frame(8'h76, 1'b0, 1'b0);
        check("esc_after_timeout", RESET_Out, 16'h0003);
        // Reset in the middle of a frame must not deliver a byte.
        chk_en = 1'b0;
        send_bits({2'b11, 8'h1B, 1'b0}, 6);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            m_held[i] = 1'b0;
            m_sticky[i] = 1'b0;
            check("midframe_reset_word", dut_w[i], 16'h0000);
        end
        m_brk = 1'b0;
        m_ext = 1'b0;
        m_code = 8'h00;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        check_counts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
